// File: rtl/fde_controller.sv
// Fetch/decode/execute sequencer: fetches 16-bit instructions over a simple
// req/ack memory port, hands them to an external execute unit and maintains
// the PC, instruction register and retired-instruction counter.
module fde_controller #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter logic [11:0] RESET_PC    = 12'h000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    output logic        o_mem_req,
    output logic [11:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    output logic [15:0] o_ir,
    output logic        o_exec_valid,
    input  logic        i_exec_done,
    input  logic        i_zero,
    output logic [2:0]  o_state,
    output logic        o_halted,
    output logic        o_fault,
    output logic [15:0] o_instr_count
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StHalt   = 3'd4,
        StFault  = 3'd5
    } state_e;

    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpBz   = 4'hD;
    localparam logic [3:0] OpHalt = 4'hF;
    // Last wait-counter value before the timeout fires.
    localparam logic [7:0] WaitLast = 8'(ACK_TIMEOUT - 1);

    state_e      state_q;
    logic [11:0] pc_q, pc_d;
    logic [15:0] ir_q;
    logic [15:0] cnt_q;
    logic [7:0]  wait_q;
    logic        mem_req_q;
    logic        exec_valid_q;
    logic        halted_q;
    logic        fault_q;
    logic [3:0]  opcode;

    assign opcode = ir_q[15:12];

    // PC to load when the current instruction retires from EXEC.
    always_comb begin
        pc_d = pc_q + 12'd1;
        if (opcode == OpJmp || (opcode == OpBz && i_zero)) begin
            pc_d = ir_q[11:0];
        end
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            ir_q         <= 16'h0000;
            cnt_q        <= 16'h0000;
            wait_q       <= 8'd0;
            mem_req_q    <= 1'b0;
            exec_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            exec_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q   <= StFetch;
                        mem_req_q <= 1'b1;
                        wait_q    <= 8'd0;
                    end
                end
                StFetch: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (i_mem_ack) begin
                        ir_q      <= i_mem_data;
                        state_q   <= StDecode;
                        mem_req_q <= 1'b0;
                    end else if (wait_q == WaitLast) begin
                        state_q   <= StFault;
                        mem_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDecode: begin
                    if (opcode == OpHalt) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                        cnt_q    <= cnt_q + 16'd1;
                    end else begin
                        state_q      <= StExec;
                        exec_valid_q <= 1'b1;
                    end
                end
                StExec: begin
                    if (i_exec_done) begin
                        pc_q      <= pc_d;
                        cnt_q     <= cnt_q + 16'd1;
                        state_q   <= StFetch;
                        mem_req_q <= 1'b1;
                        wait_q    <= 8'd0;
                    end
                end
                // HALT and FAULT are left only through reset.
                StHalt, StFault: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req     = mem_req_q;
    assign o_mem_addr    = pc_q;
    assign o_ir          = ir_q;
    assign o_exec_valid  = exec_valid_q;
    assign o_state       = state_q;
    assign o_halted      = halted_q;
    assign o_fault       = fault_q;
    assign o_instr_count = cnt_q;

endmodule

// File: tb/tb_fde_controller.sv
// Self-checking bench for fde_controller: the bench plays instruction memory
// and execute unit, and a transaction-level model tracks PC and count.
module tb_fde_controller;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        o_mem_req;
    logic [11:0] o_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;
    logic [15:0] o_ir;
    logic        o_exec_valid;
    logic        i_exec_done;
    logic        i_zero;
    logic [2:0]  o_state;
    logic        o_halted;
    logic        o_fault;
    logic [15:0] o_instr_count;

    int n_total = 0;
    int n_bad   = 0;

    // Model state
    logic [11:0] exp_pc;
    logic [15:0] exp_cnt;

    fde_controller #(
        .ACK_TIMEOUT(15),
        .RESET_PC   (12'h000)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_data   (i_mem_data),
        .o_ir         (o_ir),
        .o_exec_valid (o_exec_valid),
        .i_exec_done  (i_exec_done),
        .i_zero       (i_zero),
        .o_state      (o_state),
        .o_halted     (o_halted),
        .o_fault      (o_fault),
        .o_instr_count(o_instr_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(o_state), 32'd0);
        check({tag, "_addr"}, 32'(o_mem_addr), 32'h000);
        check({tag, "_ir"}, 32'(o_ir), 32'h0);
        check({tag, "_cnt"}, 32'(o_instr_count), 32'h0);
        check({tag, "_outs"}, {28'd0, o_mem_req, o_exec_valid, o_halted, o_fault}, 32'h0);
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_start     = 1'b0;
        i_mem_ack   = 1'b0;
        i_mem_data  = 16'h0;
        i_exec_done = 1'b0;
        i_zero      = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        exp_pc  = 12'h000;
        exp_cnt = 16'h0000;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("start_state", 32'(o_state), 32'd1);
    endtask

    // Expected PC after an instruction retires, straight from the branch rules.
    function automatic logic [11:0] next_pc(input logic [15:0] instr, input logic zero,
                                            input logic [11:0] pc);
        if (instr[15:12] == 4'hC) return instr[11:0];
        if (instr[15:12] == 4'hD && zero) return instr[11:0];
        return pc + 12'd1;
    endfunction

    // Run one instruction from a FETCH cycle; ends in the next FETCH (or HALT).
    task automatic run_instr(input logic [15:0] instr, input int ack_dly, input int done_dly,
                             input logic zero);
        check("fetch_req", 32'(o_mem_req), 32'd1);
        check("fetch_addr", 32'(o_mem_addr), 32'(exp_pc));
        repeat (ack_dly) begin
            i_start    = 1'($urandom);
            i_mem_data = 16'($urandom);
            @(negedge i_clk);
            check("fetch_wait", 32'(o_state), 32'd1);
        end
        i_start    = 1'b0;
        i_mem_ack  = 1'b1;
        i_mem_data = instr;
        @(negedge i_clk);
        i_mem_ack  = 1'b0;
        i_mem_data = 16'($urandom);
        check("decode_state", 32'(o_state), 32'd2);
        check("decode_ir", 32'(o_ir), 32'(instr));
        check("decode_req", 32'(o_mem_req), 32'd0);
        @(negedge i_clk);
        if (instr[15:12] == 4'hF) begin
            exp_cnt = exp_cnt + 16'd1;
            check("halt_state", 32'(o_state), 32'd4);
            check("halt_flag", 32'(o_halted), 32'd1);
            check("halt_cnt", 32'(o_instr_count), 32'(exp_cnt));
            check("halt_pc", 32'(o_mem_addr), 32'(exp_pc));
            return;
        end
        check("exec_state", 32'(o_state), 32'd3);
        check("exec_valid", 32'(o_exec_valid), 32'd1);
        repeat (done_dly) begin
            i_zero = 1'($urandom);
            @(negedge i_clk);
            check("exec_hold", {30'd0, o_exec_valid, 1'b0}, 32'd0);
            check("exec_hold_state", 32'(o_state), 32'd3);
        end
        i_exec_done = 1'b1;
        i_zero      = zero;
        @(negedge i_clk);
        i_exec_done = 1'b0;
        i_zero      = 1'($urandom);
        exp_pc  = next_pc(instr, zero, exp_pc);
        exp_cnt = exp_cnt + 16'd1;
        check("retire_state", 32'(o_state), 32'd1);
        check("retire_cnt", 32'(o_instr_count), 32'(exp_cnt));
        check("retire_addr", 32'(o_mem_addr), 32'(exp_pc));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] instr;

        // Reset values and idling without start
        do_reset();
        check_reset_outputs("reset");
        repeat (3) @(negedge i_clk);
        check("idle_hold", 32'(o_state), 32'd0);

        // Three sequential instructions, ack after 2, done 1 after valid
        start_run();
        for (int i = 0; i < 3; i++) run_instr(16'h1234, 2, 1, 1'b0);
        check("seq_cnt3", 32'(o_instr_count), 32'd3);
        check("seq_addr3", 32'(o_mem_addr), 32'h003);

        // JMP, BZ not taken, BZ taken
        do_reset();
        start_run();
        run_instr(16'hC0A5, 0, 0, 1'b0);
        check("jmp_target", 32'(o_mem_addr), 32'h0A5);
        run_instr(16'hD010, 1, 0, 1'b0);
        check("bz_not_taken", 32'(o_mem_addr), 32'h0A6);
        run_instr(16'hD010, 0, 2, 1'b1);
        check("bz_taken", 32'(o_mem_addr), 32'h010);

        // PC wrap from 0xFFF
        run_instr(16'hCFFF, 0, 0, 1'b1);
        run_instr(16'h0000, 0, 0, 1'b1);
        check("pc_wrap", 32'(o_mem_addr), 32'h000);

        // Random program then HALT
        for (int i = 0; i < 40; i++) begin
            op    = 4'($urandom_range(0, 14));
            instr = {op, 12'($urandom)};
            run_instr(instr, ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom));
        end
        run_instr({4'hF, 12'($urandom)}, 1, 0, 1'b0);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            check("halt_stays", 32'(o_state), 32'd4);
            check("halt_noreq", 32'(o_mem_req), 32'd0);
            check("halt_cnt_frozen", 32'(o_instr_count), 32'(exp_cnt));
        end
        do_reset();
        check_reset_outputs("halt_reset");

        // Ack withheld for the full timeout
        start_run();
        repeat (15) @(negedge i_clk);
        check("fault_state", 32'(o_state), 32'd5);
        check("fault_flag", 32'(o_fault), 32'd1);
        check("fault_noreq", 32'(o_mem_req), 32'd0);
        i_mem_ack  = 1'b1;
        i_mem_data = 16'hABCD;
        i_start    = 1'b1;
        repeat (3) @(negedge i_clk);
        i_mem_ack = 1'b0;
        i_start   = 1'b0;
        check("fault_stays", 32'(o_state), 32'd5);
        check("fault_ir_frozen", 32'(o_ir), 32'h0);
        check("fault_pc_frozen", 32'(o_mem_addr), 32'h000);
        check("fault_cnt_frozen", 32'(o_instr_count), 32'h0);

        // Ack on the last allowed cycle still wins
        do_reset();
        start_run();
        run_instr(16'h1111, 14, 0, 1'b0);
        check("late_ack_nofault", 32'(o_fault), 32'd0);

        // Asynchronous reset in the first EXEC cycle
        i_mem_ack  = 1'b1;
        i_mem_data = 16'h2222;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        check("pre_reset_valid", 32'(o_exec_valid), 32'd1);
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("post_reset_idle", 32'(o_state), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fde_controller.md
FDE_CONTROLLER -- requirements
Module: fde_controller

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 15, meaning the number of cycles FETCH waits for i_mem_ack before declaring a fault (legal range 1..255).
REQ-002 The block SHALL have parameter RESET_PC, default 12'h000, meaning the PC value loaded on reset.
REQ-003 The block SHALL have port i_clk  input  1  system clock; all state changes on rising edge.
REQ-004 The block SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port i_start  input  1  single-cycle pulse that starts execution from IDLE.
REQ-006 The block SHALL have port o_mem_req  output  1  instruction-memory read request.
REQ-007 The block SHALL have port o_mem_addr  output  12  instruction address; equals current PC.
REQ-008 The block SHALL have port i_mem_ack  input  1  memory read data valid.
REQ-009 The block SHALL have port i_mem_data  input  16  instruction word; sampled only when i_mem_ack=1 in FETCH.
REQ-010 The block SHALL have port o_ir  output  16  instruction register.
REQ-011 The block SHALL have port o_exec_valid  output  1  one-cycle pulse handing o_ir to the execute unit.
REQ-012 The block SHALL have port i_exec_done  input  1  execute unit finished the current instruction.
REQ-013 The block SHALL have port i_zero  input  1  zero flag from the execute unit; sampled with i_exec_done.
REQ-014 The block SHALL have port o_state  output  3  current state encoding.
REQ-015 The block SHALL have port o_halted  output  1  high in HALT state.
REQ-016 The block SHALL have port o_fault  output  1  high in FAULT state.
REQ-017 The block SHALL have port o_instr_count  output  16  retired-instruction counter.

Function
REQ-018 The state encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4, FAULT=5.
REQ-019 In IDLE, i_start=1 SHALL move to FETCH on the next edge; otherwise the block stays in IDLE.
REQ-020 In FETCH, o_mem_req SHALL be 1 and o_mem_addr SHALL equal PC; on i_mem_ack=1, o_ir <= i_mem_data and the next state is DECODE.
REQ-021 FETCH SHALL count wait cycles from 0; if ACK_TIMEOUT cycles elapse without ack, the next state SHALL be FAULT.
REQ-022 The wait counter SHALL clear on every entry to FETCH, and an ack in the same cycle the counter reaches ACK_TIMEOUT SHALL win over the timeout.
REQ-023 DECODE SHALL last exactly 1 cycle: opcode o_ir[15:12]=4'hF goes to HALT; any other opcode goes to EXEC.
REQ-024 On entry to EXEC, o_exec_valid SHALL pulse high for exactly the first EXEC cycle; the block then holds in EXEC until i_exec_done=1.
REQ-025 If i_exec_done=1 in the first EXEC cycle, it SHALL be accepted in that cycle.
REQ-026 On exiting EXEC with opcode 4'hC (JMP), PC SHALL load o_ir[11:0].
REQ-027 On exiting EXEC with opcode 4'hD (BZ), PC SHALL load o_ir[11:0] if i_zero=1, else PC+1.
REQ-028 On exiting EXEC with any other opcode, PC SHALL load PC+1 modulo 2^12, so 12'hFFF wraps to 12'h000.
REQ-029 On exiting EXEC, o_instr_count SHALL increment by 1, wrapping 16'hFFFF to 0, and the next state SHALL be FETCH.
REQ-030 HALT SHALL increment o_instr_count once on entry, leave PC pointing at the HALT instruction, and be exited only by reset.
REQ-031 FAULT SHALL be exited only by reset; PC, o_ir and o_instr_count SHALL be frozen in FAULT.
REQ-032 o_mem_req SHALL be 0 in every state except FETCH, and o_exec_valid SHALL be 0 outside EXEC.
REQ-033 i_start SHALL be ignored in every state except IDLE.

Reset
REQ-034 While i_reset=1 and asynchronously on assertion, the block SHALL set state IDLE, PC=RESET_PC, o_ir=0, o_instr_count=0, wait counter=0, and o_mem_req, o_exec_valid, o_halted and o_fault all to 0.
REQ-035 Reset asserted mid-FETCH or mid-EXEC SHALL abort the operation with no PC or count update.

Verification
REQ-036 Reset, start; memory acks after 2 cycles with 16'h1234 and exec_done arrives 1 cycle after valid -> addresses 0,1,2 are fetched in order, o_instr_count = 3 after 3 instructions.
REQ-037 PC=0 holds 16'hC0A5 (JMP) -> the next o_mem_addr is 12'h0A5; BZ 16'hD010 with i_zero=0 -> next 12'h0A6, and with i_zero=1 -> next 12'h010.
REQ-038 JMP to 12'hFFF, then a non-branch instruction -> the next fetch address is 12'h000.
REQ-039 Instruction 16'hF000 -> o_halted=1, o_state=4, o_mem_req stays 0 while i_start is pulsed; reset returns the block to IDLE.
REQ-040 Withhold ack for 15 cycles -> o_fault=1 and o_state=5; ack arriving on the 15th cycle -> DECODE with no fault.
REQ-041 Assert i_reset while in EXEC -> all outputs are at reset values immediately (asynchronously), and PC=RESET_PC.
